div_sequencer: RTL

//  Multi-cycle unsigned restoring divider controller that drives the combinational datapath

---
 rtl/div_sequencer_pkg.sv | 17 +
 rtl/div_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared encodings for the restoring-divider sequencer and the function unit it drives.
package risc_div_pkg;

  // Function-select codes understood by the function unit.
  localparam logic [4:0] FS_PASS = 5'b00000;
  localparam logic [4:0] FS_SUB  = 5'b00101;
  localparam logic [4:0] FS_SHL  = 5'b10000;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SUB   = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider controller. Drives an external
// combinational function unit: one shift cycle then one subtract cycle per
// quotient bit.
//
// state | meaning
// IDLE  | waiting for start; results held
// SHIFT | R <- {R<<1, next dividend bit}, remember shifted-out MSB
// SUB   | trial subtract R - D; keep it if no borrow or MSB overflowed
// DONE  | publish results, pulse done, drop busy
module div_sequencer #(
  parameter int BITS = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            dz,
  output logic [BITS-1:0] fu_a,
  output logic [BITS-1:0] fu_b,
  output logic [4:0]      fu_fs,
  output logic [4:0]      fu_sh,
  input  logic [BITS-1:0] fu_out,
  input  logic            fu_c
);
  import risc_div_pkg::*;

  div_state_e      state_q, state_d;
  logic [BITS-1:0] r_q, r_d;
  logic [BITS-1:0] q_q, q_d;
  logic [BITS-1:0] d_q, d_d;
  logic            ov_q, ov_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  // Remembers that the accepted divisor was zero until the DONE state publishes it.
  logic            zdiv_q, zdiv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;
  logic [BITS-1:0] quot_q, quot_d;
  logic [BITS-1:0] rem_q, rem_d;

  assign busy      = busy_q;
  assign done      = done_q;
  assign dz        = dz_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

  // Next-state, datapath updates and function-unit drive for the current state.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    zdiv_d  = zdiv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    fu_a    = '0;
    fu_b    = '0;
    fu_fs   = FS_PASS;
    fu_sh   = 5'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d    = dividend;
          r_d    = '0;
          d_d    = divisor;
          cnt_d  = '0;
          ov_d   = 1'b0;
          busy_d = 1'b1;
          if (divisor == '0) begin
            zdiv_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            zdiv_d  = 1'b0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        fu_a    = r_q;
        fu_fs   = FS_SHL;
        fu_sh   = 5'd1;
        r_d     = {fu_out[BITS-1:1], q_q[BITS-1]};
        ov_d    = r_q[BITS-1];
        state_d = ST_SUB;
      end
      ST_SUB: begin
        fu_a  = r_q;
        fu_b  = d_q;
        fu_fs = FS_SUB;
        // With OV set the true remainder exceeds D, so the wrapped difference is exact.
        if (ov_q || fu_c) begin
          r_d = fu_out;
          q_d = {q_q[BITS-2:0], 1'b1};
        end else begin
          q_d = {q_q[BITS-2:0], 1'b0};
        end
        cnt_d   = cnt_q + CNTW'(1);
        state_d = (cnt_q == CNTW'(BITS-1)) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (zdiv_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = q_q;
          rem_d  = r_q;
          dz_d   = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
      zdiv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
      zdiv_q  <= zdiv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

endmodule
